game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Frame-synchronous game sequencer for the Nidhogg VGA design. It sits beside the overlay pipeline (background → board_control → playerL → playerR → win). It decodes keyboard commands into the one-hot screen selects consumed by the overlay stages. It gates player movement to one update per frame, detects goal crossings, keeps per-player scores and times the countdown and win screens.

## Interface
Parameters:
- LEFT_GOAL, 12'd64: right player wins when rp_x ≤ this value.
- RIGHT_GOAL, 12'd960: left player wins when lp_x ≥ this value.
- COUNTDOWN_FRAMES, 120: frames spent in COUNTDOWN before PLAY.
- WIN_FRAMES, 180: frames the win screen is held.
- ROUND_FRAMES, 3600: round time limit in frames (only with GAME_FLOW_ROUND_TIMER_EN).

Ports:
- clk  in  1  65 MHz pixel clock (pclk).
- rst  in  1  reset, asynchronous, active-low.
- vsync  in  1  vsync from the timing chain; its rising edge marks the frame boundary.
- key_start  in  1  start/confirm key level, already synchronous to clk.
- key_help  in  1  help key level, synchronous.
- key_map  in  1  map toggle key level, synchronous.
- lp_x  in  12  left player x position.
- rp_x  in  12  right player x position.
- menu, help, select_map, game_castle, game_forest, win  out  1 each  one-hot screen select.
- winner  out  1  0 = left player, 1 = right player; valid while win = 1.
- frame_tick  out  1  one-cycle pulse per frame.
- move_en  out  1  one-cycle movement strobe, PLAY only.
- respawn  out  1  one-cycle pulse; players return to start positions.
- score_l, score_r  out  4 each  round wins per player.

## Operation
- Edge detect: each key input and vsync is registered once. edge = level & ~level_q. frame_tick = vsync edge.
- Map register: 0 = castle, 1 = forest. Reset value 0.
- State MENU:
  - start edge → SELECT, and score_l and score_r clear to 0.
  - Otherwise, help edge → HELP.
  - If both edges arrive in the same cycle, start has priority.
- State HELP: a start or help edge → MENU.
- State SELECT:
  - map edge toggles the map register.
  - start edge → COUNTDOWN with a respawn pulse and frame counter cleared.
  - If map and start edges arrive in the same cycle, the toggle applies first, then the transition.
- State COUNTDOWN: the frame counter increments on frame_tick. When frame_tick arrives with counter = COUNTDOWN_FRAMES-1, go to PLAY and clear the counter.
- State PLAY:
  - move_en = frame_tick.
  - Goal check is evaluated only on frame_tick cycles.
  - Both goals crossed in the same frame → draw: respawn pulse, go to COUNTDOWN, scores unchanged.
  - Only the left goal condition holds (lp_x ≥ RIGHT_GOAL) → WIN, winner = 0, score_l +1.
  - Only the right goal condition holds (rp_x ≤ LEFT_GOAL) → WIN, winner = 1, score_r +1.
  - Scores saturate at 15.
- State WIN:
  - The counter counts frames. After WIN_FRAMES ticks → SELECT with a respawn pulse.
  - A start edge exits early with the same result.
- Screen outputs:
  - game_castle = (COUNTDOWN or PLAY) and map = 0.
  - game_forest = (COUNTDOWN or PLAY) and map = 1.
  - All other screen outputs are a direct state decode.
  - Exactly one screen output is high at all times.

## Timing
- Every output is registered.
- Reset values: menu = 1; all other outputs 0. State = MENU, map = 0, counters = 0.
- Reset is asserted asynchronously at any point, including mid-PLAY or mid-WIN. Release is synchronous: the first state change happens no earlier than the second clk edge after rst rises.
- Latency from a key or vsync rising edge at the input to the state/output change: 2 clk cycles (one for the input register, one for the state register).
- frame_tick, move_en and respawn are each exactly one clk wide. move_en is coincident with frame_tick.
- respawn asserts in the same cycle as the state register enters its target state.
- Frame counter width is ceil(log2(max(COUNTDOWN_FRAMES, WIN_FRAMES, ROUND_FRAMES))). The counter clears on every state entry.

## Configuration
- GAME_FLOW_ROUND_TIMER_EN defined:
  - PLAY counts frames.
  - If frame_tick arrives with counter = ROUND_FRAMES-1 and no goal is crossed, the round is a draw: respawn pulse, go to COUNTDOWN, scores unchanged.
  - A goal crossing on the same tick takes priority over the timeout.
- Macro undefined: PLAY has no time limit, and the counter holds at 0 in PLAY.

## Structure
- Shared package game_pkg holds:
  - the state enum (MENU, HELP, SELECT, COUNTDOWN, PLAY, WIN);
  - the screen one-hot index constants;
  - the default goal and frame constants, shared with playerL/playerR.
- One sub-module, edge_det: a registered rising-edge detector, instantiated four times (start, help, map, vsync).

## Test plan
- Reset → menu = 1, all other outputs 0, scores 0. Then start edge → select_map = 1 two cycles later.
- In SELECT: map edge, then start edge → game_forest = 1 after COUNTDOWN_FRAMES vsync edges, one respawn pulse, move_en once per vsync.
- PLAY with lp_x = 960 at a vsync → win = 1, winner = 0, score_l = 1. After 180 vsyncs → select_map = 1 with respawn.
- PLAY with lp_x = 960 and rp_x = 64 on the same vsync → COUNTDOWN, scores unchanged, respawn = 1.
- Reset asserted mid-PLAY → outputs return to reset values immediately. Sixteen consecutive left wins → score_l stays 15.
- GAME_FLOW_ROUND_TIMER_EN defined, ROUND_FRAMES = 10, no goal crossed → COUNTDOWN on the 10th vsync in PLAY.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game flow sequencer and the player overlay stages:
// state encoding, screen one-hot bit positions, default goal/frame constants.
package game_pkg;

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        HELP      = 3'd1,
        SELECT    = 3'd2,
        COUNTDOWN = 3'd3,
        PLAY      = 3'd4,
        WIN       = 3'd5
    } game_state_t;

    // Bit positions of the screen one-hot vector {menu, help, select_map, castle, forest, win}
    localparam int SCR_W      = 6;
    localparam int SCR_MENU   = 5;
    localparam int SCR_HELP   = 4;
    localparam int SCR_SELECT = 3;
    localparam int SCR_CASTLE = 2;
    localparam int SCR_FOREST = 1;
    localparam int SCR_WIN    = 0;

    // Defaults shared with playerL/playerR
    localparam logic [11:0] DEF_LEFT_GOAL        = 12'd64;
    localparam logic [11:0] DEF_RIGHT_GOAL       = 12'd960;
    localparam int          DEF_COUNTDOWN_FRAMES = 120;
    localparam int          DEF_WIN_FRAMES       = 180;
    localparam int          DEF_ROUND_FRAMES     = 3600;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Score counter that sticks at 15 instead of wrapping
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Screen select for a given state; the game screen depends on the chosen map
    function automatic logic [SCR_W-1:0] screen_decode(input game_state_t st, input logic map_sel);
        logic [SCR_W-1:0] s;
        s = '0;
        case (st)
            MENU:            s[SCR_MENU]   = 1'b1;
            HELP:            s[SCR_HELP]   = 1'b1;
            SELECT:          s[SCR_SELECT] = 1'b1;
            COUNTDOWN, PLAY: begin
                if (map_sel) s[SCR_FOREST] = 1'b1;
                else         s[SCR_CASTLE] = 1'b1;
            end
            WIN:             s[SCR_WIN]    = 1'b1;
            default:         s[SCR_MENU]   = 1'b1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_edge_det.sv
// Registered rising-edge detector: the input is registered once, then compared
// with its one-cycle-older copy, so the pulse depends on flops only.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_r;
    logic level_q;

    // Input register plus delayed copy for edge comparison
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_r <= 1'b0;
            level_q <= 1'b0;
        end else begin
            level_r <= level;
            level_q <= level_r;
        end
    end

    assign rise = level_r & ~level_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Frame-synchronous game sequencer: keyboard edges drive the menu/help/select
// screens, vsync paces countdown, play and win timing, goals update scores.
// Optional build macro: GAME_FLOW_ROUND_TIMER_EN adds a per-round time limit
// (ROUND_FRAMES) that ends an undecided round as a draw.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter logic [11:0] LEFT_GOAL        = DEF_LEFT_GOAL,
    parameter logic [11:0] RIGHT_GOAL       = DEF_RIGHT_GOAL,
    parameter int          COUNTDOWN_FRAMES = DEF_COUNTDOWN_FRAMES,
    parameter int          WIN_FRAMES       = DEF_WIN_FRAMES,
    parameter int          ROUND_FRAMES     = DEF_ROUND_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        key_start,
    input  logic        key_help,
    input  logic        key_map,
    input  logic [11:0] lp_x,
    input  logic [11:0] rp_x,
    output logic        menu,
    output logic        help,
    output logic        select_map,
    output logic        game_castle,
    output logic        game_forest,
    output logic        win,
    output logic        winner,
    output logic        frame_tick,
    output logic        move_en,
    output logic        respawn,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic [2:0]  state_dbg
);

    localparam int CNT_MAX = max3(COUNTDOWN_FRAMES, WIN_FRAMES, ROUND_FRAMES);
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_FRAMES - 1);
`ifdef GAME_FLOW_ROUND_TIMER_EN
    localparam logic [CNT_W-1:0] RND_LAST = CNT_W'(ROUND_FRAMES - 1);
`endif

    logic start_e, help_e, map_e, tick_e;

    edge_det u_start (.clk(clk), .rst(rst), .level(key_start), .rise(start_e));
    edge_det u_help  (.clk(clk), .rst(rst), .level(key_help),  .rise(help_e));
    edge_det u_map   (.clk(clk), .rst(rst), .level(key_map),   .rise(map_e));
    edge_det u_vsync (.clk(clk), .rst(rst), .level(vsync),     .rise(tick_e));

    game_state_t      state, state_n;
    logic             map_q, map_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       score_l_q, score_l_n;
    logic [3:0]       score_r_q, score_r_n;
    logic             winner_q, winner_n;
    logic             resp_n;
    logic [SCR_W-1:0] screen_q;
    logic             goal_l, goal_r;

    assign goal_l = (lp_x >= RIGHT_GOAL);
    assign goal_r = (rp_x <= LEFT_GOAL);

    // Next-state, map, counter and score decisions for the current cycle
    always_comb begin
        state_n   = state;
        map_n     = map_q;
        cnt_n     = cnt;
        score_l_n = score_l_q;
        score_r_n = score_r_q;
        winner_n  = winner_q;
        resp_n    = 1'b0;
        case (state)
            MENU: begin
                if (start_e) begin
                    state_n   = SELECT;
                    score_l_n = 4'd0;
                    score_r_n = 4'd0;
                end else if (help_e) begin
                    state_n = HELP;
                end
            end
            HELP: begin
                if (start_e || help_e) state_n = MENU;
            end
            SELECT: begin
                // Toggle first so a same-cycle start uses the new map
                if (map_e) map_n = ~map_q;
                if (start_e) begin
                    state_n = COUNTDOWN;
                    resp_n  = 1'b1;
                end
            end
            COUNTDOWN: begin
                if (tick_e) begin
                    if (cnt == CD_LAST) state_n = PLAY;
                    else                cnt_n   = cnt + 1'b1;
                end
            end
            PLAY: begin
                if (tick_e) begin
                    if (goal_l && goal_r) begin
                        state_n = COUNTDOWN;
                        resp_n  = 1'b1;
                    end else if (goal_l) begin
                        state_n   = WIN;
                        winner_n  = 1'b0;
                        score_l_n = sat_inc(score_l_q);
                    end else if (goal_r) begin
                        state_n   = WIN;
                        winner_n  = 1'b1;
                        score_r_n = sat_inc(score_r_q);
                    end
`ifdef GAME_FLOW_ROUND_TIMER_EN
                    else if (cnt == RND_LAST) begin
                        state_n = COUNTDOWN;
                        resp_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
`endif
                end
            end
            WIN: begin
                if (start_e || (tick_e && cnt == WIN_LAST)) begin
                    state_n = SELECT;
                    resp_n  = 1'b1;
                end else if (tick_e) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = MENU;
        endcase
        // Every state entry starts the frame counter from zero
        if (state_n != state) cnt_n = '0;
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= MENU;
            map_q      <= 1'b0;
            cnt        <= '0;
            score_l_q  <= 4'd0;
            score_r_q  <= 4'd0;
            winner_q   <= 1'b0;
            respawn    <= 1'b0;
            frame_tick <= 1'b0;
            move_en    <= 1'b0;
            screen_q   <= screen_decode(MENU, 1'b0);
        end else begin
            state      <= state_n;
            map_q      <= map_n;
            cnt        <= cnt_n;
            score_l_q  <= score_l_n;
            score_r_q  <= score_r_n;
            winner_q   <= winner_n;
            respawn    <= resp_n;
            frame_tick <= tick_e;
            move_en    <= (state == PLAY) && tick_e;
            screen_q   <= screen_decode(state_n, map_n);
        end
    end

    assign menu        = screen_q[SCR_MENU];
    assign help        = screen_q[SCR_HELP];
    assign select_map  = screen_q[SCR_SELECT];
    assign game_castle = screen_q[SCR_CASTLE];
    assign game_forest = screen_q[SCR_FOREST];
    assign win         = screen_q[SCR_WIN];
    assign winner      = winner_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: navigation table, then hand-written sequences for
// countdown, wins, draws, score saturation, asynchronous reset and round timer.
module tb_game_flow_ctrl;
    import game_pkg::*;

    localparam int CD_FRAMES  = 120;
    localparam int WIN_FR     = 180;
    localparam int ROUND_T    = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vsync = 1'b0;
    logic        key_start = 1'b0;
    logic        key_help = 1'b0;
    logic        key_map = 1'b0;
    logic [11:0] lp_x = 12'd500;
    logic [11:0] rp_x = 12'd500;
    logic        menu, help, select_map, game_castle, game_forest, win;
    logic        winner, frame_tick, move_en, respawn;
    logic [3:0]  score_l, score_r;
    logic [2:0]  state_dbg;

    // Clock
    always #5 clk = ~clk;

    game_flow_ctrl #(
        .LEFT_GOAL(12'd64), .RIGHT_GOAL(12'd960),
        .COUNTDOWN_FRAMES(CD_FRAMES), .WIN_FRAMES(WIN_FR), .ROUND_FRAMES(ROUND_T)
    ) dut (
        .clk(clk), .rst(rst), .vsync(vsync),
        .key_start(key_start), .key_help(key_help), .key_map(key_map),
        .lp_x(lp_x), .rp_x(rp_x),
        .menu(menu), .help(help), .select_map(select_map),
        .game_castle(game_castle), .game_forest(game_forest), .win(win),
        .winner(winner), .frame_tick(frame_tick), .move_en(move_en), .respawn(respawn),
        .score_l(score_l), .score_r(score_r), .state_dbg(state_dbg)
    );

    // Expected-state model, updated by the test sequence
    game_state_t m_state = MENU;
    logic        m_map = 1'b0;
    logic        m_winner = 1'b0;
    logic [3:0]  m_sl = 4'd0;
    logic [3:0]  m_sr = 4'd0;

    logic [20:0] exp_q[$];
    int          n_vec = 0;
    int          n_miss = 0;

    function automatic logic [20:0] actual();
        return {state_dbg, menu, help, select_map, game_castle, game_forest, win,
                winner, frame_tick, move_en, respawn, score_l, score_r};
    endfunction

    function automatic logic [5:0] model_screen();
        logic game;
        game = (m_state == COUNTDOWN) || (m_state == PLAY);
        return {m_state == MENU, m_state == HELP, m_state == SELECT,
                game && !m_map, game && m_map, m_state == WIN};
    endfunction

    task automatic push_exp(input logic tick, input logic mv, input logic rs);
        exp_q.push_back({m_state, model_screen(), m_winner, tick, mv, rs, m_sl, m_sr});
    endtask

    task automatic check(input string name);
        logic [20:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: got %h, expected queue empty", name, actual());
        end else begin
            e = exp_q.pop_front();
            if (actual() !== e) begin
                n_miss++;
                $display("FAIL %s: got %h expected %h", name, actual(), e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle key pulse; outputs are checked two edges later, then one idle cycle
    task automatic press_chk(input string name, input logic s, input logic h,
                             input logic m, input logic rs);
        push_exp(1'b0, 1'b0, rs);
        key_start = s; key_help = h; key_map = m;
        step();
        key_start = 1'b0; key_help = 1'b0; key_map = 1'b0;
        step();
        check(name);
        step();
        push_exp(1'b0, 1'b0, 1'b0);
        check({name, "_idle"});
    endtask

    // One vsync pulse; frame_tick/move_en/respawn checked, then checked low again
    task automatic frame_chk(input string name, input logic mv, input logic rs);
        push_exp(1'b1, mv, rs);
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        step();
        check(name);
        step();
        push_exp(1'b0, 1'b0, 1'b0);
        check({name, "_idle"});
    endtask

    task automatic run_countdown();
        for (int i = 0; i < CD_FRAMES; i++) begin
            if (i == CD_FRAMES - 1) m_state = PLAY;
            frame_chk("countdown", 1'b0, 1'b0);
        end
    endtask

    typedef struct {
        logic        s;
        logic        h;
        logic        m;
        game_state_t st;
        logic        mp;
    } nav_t;

    nav_t nav[9];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nav[0] = '{1'b0, 1'b1, 1'b0, HELP,   1'b0};
        nav[1] = '{1'b0, 1'b1, 1'b0, MENU,   1'b0};
        nav[2] = '{1'b0, 1'b1, 1'b0, HELP,   1'b0};
        nav[3] = '{1'b1, 1'b0, 1'b0, MENU,   1'b0};
        nav[4] = '{1'b1, 1'b1, 1'b0, SELECT, 1'b0};
        nav[5] = '{1'b0, 1'b0, 1'b1, SELECT, 1'b1};
        nav[6] = '{1'b0, 1'b1, 1'b0, SELECT, 1'b1};
        nav[7] = '{1'b0, 1'b0, 1'b1, SELECT, 1'b0};
        nav[8] = '{1'b0, 1'b0, 1'b1, SELECT, 1'b1};

        // Reset
        step();
        step();
        push_exp(1'b0, 1'b0, 1'b0);
        check("reset");
        rst = 1'b1;
        step();
        push_exp(1'b0, 1'b0, 1'b0);
        check("reset_release");

        // Menu / help / select navigation table
        for (int i = 0; i < 9; i++) begin
            m_state = nav[i].st;
            m_map   = nav[i].mp;
            press_chk($sformatf("nav%0d", i), nav[i].s, nav[i].h, nav[i].m, 1'b0);
        end

        // Forest round: countdown, play moves, left win, win hold
        m_state = COUNTDOWN;
        press_chk("sel_start", 1'b1, 1'b0, 1'b0, 1'b1);
        run_countdown();
        for (int i = 0; i < 3; i++) frame_chk("play_move", 1'b1, 1'b0);
        lp_x = 12'd960;
        m_state = WIN; m_winner = 1'b0; m_sl = 4'd1;
        frame_chk("win_left", 1'b1, 1'b0);
        lp_x = 12'd500;
        for (int i = 0; i < WIN_FR; i++) begin
            if (i == WIN_FR - 1) m_state = SELECT;
            frame_chk("win_hold", 1'b0, i == WIN_FR - 1);
        end

        // Map and start on the same cycle: toggle back to castle, then countdown
        m_map = 1'b0; m_state = COUNTDOWN;
        press_chk("map_start_same", 1'b1, 1'b0, 1'b1, 1'b1);
        run_countdown();

        // Both goals on one frame: draw
        lp_x = 12'd960; rp_x = 12'd64;
        m_state = COUNTDOWN;
        frame_chk("draw", 1'b1, 1'b1);
        lp_x = 12'd500; rp_x = 12'd500;
        run_countdown();

        // Right player win, early exit with start
        rp_x = 12'd64;
        m_state = WIN; m_winner = 1'b1; m_sr = 4'd1;
        frame_chk("win_right", 1'b1, 1'b0);
        rp_x = 12'd500;
        m_state = SELECT;
        press_chk("win_early", 1'b1, 1'b0, 1'b0, 1'b1);

        // Sixteen left wins: score saturates at 15
        for (int r = 0; r < 16; r++) begin
            m_state = COUNTDOWN;
            press_chk("round_start", 1'b1, 1'b0, 1'b0, 1'b1);
            run_countdown();
            lp_x = 12'd960;
            m_state = WIN; m_winner = 1'b0;
            m_sl = (m_sl == 4'd15) ? 4'd15 : m_sl + 4'd1;
            frame_chk("win_sat", 1'b1, 1'b0);
            lp_x = 12'd500;
            m_state = SELECT;
            press_chk("win_exit", 1'b1, 1'b0, 1'b0, 1'b1);
        end
        n_vec++;
        if (score_l !== 4'd15) begin
            n_miss++;
            $display("FAIL score_sat: got %0d expected 15", score_l);
        end

        // Asynchronous reset in the middle of PLAY
        m_state = COUNTDOWN;
        press_chk("pre_rst_start", 1'b1, 1'b0, 1'b0, 1'b1);
        run_countdown();
        frame_chk("play_pre_rst", 1'b1, 1'b0);
        vsync = 1'b1;
        step();
        #2 rst = 1'b0;
        #1;
        m_state = MENU; m_map = 1'b0; m_winner = 1'b0; m_sl = 4'd0; m_sr = 4'd0;
        push_exp(1'b0, 1'b0, 1'b0);
        check("async_reset");
        vsync = 1'b0;
        step();
        step();
        push_exp(1'b0, 1'b0, 1'b0);
        check("reset_held");
        rst = 1'b1;
        m_state = SELECT;
        press_chk("menu_start_after_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        m_state = COUNTDOWN;
        press_chk("castle_after_rst", 1'b1, 1'b0, 1'b0, 1'b1);
        run_countdown();

        // Round time limit
`ifdef GAME_FLOW_ROUND_TIMER_EN
        for (int i = 0; i < ROUND_T; i++) begin
            if (i == ROUND_T - 1) m_state = COUNTDOWN;
            frame_chk("round_timeout", 1'b1, i == ROUND_T - 1);
        end
`else
        for (int i = 0; i < ROUND_T + 2; i++) frame_chk("no_timeout", 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
